reservation_station: RTL and testbench
======================================

# reservation_station

Out-of-order issue buffer that feeds the integer ALU. Holds up to RS_SIZE decoded instructions whose source operands are either values or pending ROB tags, snoops the common data bus (CDB) to resolve tags, and each cycle dispatches the oldest-by-slot ready entry to the ALU through a registered one-cycle `en` pulse. Sits between the decoder/issue stage and the ALU; the ALU's `rob_id`, `data_j`, `data_k`, `imm` and `type` inputs are driven from this block.

## Interface
- RS_SIZE, 8: number of entries (power of two, 2..32).
- clk_in  in  1  clock.
- rst_in  in  1  reset, asynchronous, active-high.
- rdy_in  in  1  global ready; low freezes all state.
- flush  in  1  misprediction flush; synchronous clear of all entries.
- issue_valid  in  1  issue request this cycle.
- issue_rob_id  in  32  destination ROB tag.
- issue_type  in  5  ALU op type (same encoding the ALU consumes).
- issue_qj_busy / issue_qk_busy  in  1 each  operand j/k still pending.
- issue_qj / issue_qk  in  32 each  ROB tag producing j/k (valid when busy).
- issue_vj / issue_vk  in  32 each  operand value (valid when not busy).
- issue_imm  in  32  immediate.
- full  out  1  no free entry (combinational from current state).
- cdb_valid  in  1  broadcast valid.
- cdb_rob_id  in  32  broadcast tag.
- cdb_value  in  32  broadcast result.
- alu_en  out  1  dispatch pulse to ALU (registered).
- alu_rob_id, alu_data_j, alu_data_k, alu_imm  out  32 each  registered dispatch payload.
- alu_type  out  5  registered dispatch op type.

## Operation
- Per entry: busy, rob_id, type, qj_busy, qj, vj, qk_busy, qk, vk, imm.
- Reset (async): all busy=0; alu_en=0; all alu_* payload outputs=0.
- Issue: when issue_valid && !full at the edge, the lowest-index non-busy entry is written and marked busy. issue_valid while full is dropped silently (issuer's responsibility).
- Issue-time forwarding: if cdb_valid and issue_qj_busy and issue_qj==cdb_rob_id in the issue cycle, the entry stores vj=cdb_value, qj_busy=0; same for k independently.
- Wakeup: every busy entry with qj_busy and qj==cdb_rob_id under cdb_valid captures vj=cdb_value, clears qj_busy; same for k. j and k may wake in the same cycle.
- Ready: busy && !qj_busy && !qk_busy, evaluated on registered state (entry written or woken at edge N is first eligible in the cycle after N).
- Dispatch: lowest-index ready entry selected; at the edge alu_en<=1, payload registers loaded from it, entry busy<=0. No ready entry: alu_en<=0, payload registers hold.
- Issue, wakeup and dispatch may all occur in one cycle; the slot freed by dispatch is not reusable by an issue in that same cycle.
- full = all entries busy (ignores a same-cycle dispatch; conservative).
- Flush (rdy_in high): at the edge all busy<=0, alu_en<=0; concurrent issue and dispatch are discarded.
- rdy_in low: no state changes at all (entries, alu_en, payload hold); CDB and issue inputs ignored.

## Timing
- Minimum issue-to-ALU latency: issue at edge N with both operands ready -> dispatched at edge N+1 -> alu_en high during cycle N+1..N+2.
- CDB wake at edge N -> earliest dispatch at edge N+1.
- alu_en is high for exactly one cycle per dispatched entry; back-to-back dispatch allowed every cycle.
- Throughput: one issue and one dispatch per cycle.
- full responds combinationally to the busy vector; no reset-to-full transient (full=0 after reset).

## Test plan
- Reset then issue rob_id=3, type=ADD, vj=5, vk=7, both ready -> alu_en high exactly one cycle, 2 edges later, with alu_rob_id=3, data_j=5, data_k=7; full stays 0.
- Issue rob_id=4 with qj_busy, qj=2; two cycles later cdb_valid rob_id=2 value=0x10 -> alu_en next-after-wake cycle with data_j=0x10; no dispatch before CDB.
- Issue rob_id=9 with qk=6 while cdb_valid rob_id=6 value=0xAB in the same cycle -> entry ready immediately, dispatched next edge with data_k=0xAB.
- Fill all 8 entries with pending qj=1 -> full=1; extra issue dropped; CDB rob_id=1 -> 8 consecutive alu_en pulses in slot order, full drops after first dispatch edge.
- Entries occupied + flush with concurrent issue -> next cycle full=0, alu_en=0, no later dispatch of flushed or concurrently issued entries.
- Hold rdy_in low for 3 cycles with a ready entry and CDB activity -> no alu_en, no wakeup; dispatch resumes on the first edge rdy_in is high; assert rst_in mid-operation -> alu_en and outputs 0 immediately.

Source files
------------

// File: rtl/reservation_station.sv
// reservation_station: out-of-order issue buffer for the integer ALU; snoops the CDB to resolve
// pending operand tags and dispatches the lowest-index ready entry as a registered one-cycle pulse.
module reservation_station #(
  parameter int RS_SIZE = 8
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic        flush,
  input  logic        issue_valid,
  input  logic [31:0] issue_rob_id,
  input  logic [4:0]  issue_type,
  input  logic        issue_qj_busy,
  input  logic        issue_qk_busy,
  input  logic [31:0] issue_qj,
  input  logic [31:0] issue_qk,
  input  logic [31:0] issue_vj,
  input  logic [31:0] issue_vk,
  input  logic [31:0] issue_imm,
  output logic        full,
  input  logic        cdb_valid,
  input  logic [31:0] cdb_rob_id,
  input  logic [31:0] cdb_value,
  output logic        alu_en,
  output logic [31:0] alu_rob_id,
  output logic [31:0] alu_data_j,
  output logic [31:0] alu_data_k,
  output logic [31:0] alu_imm,
  output logic [4:0]  alu_type
);
  localparam int IW = $clog2(RS_SIZE);
  logic [RS_SIZE-1:0] busy_q, busy_d, qj_busy_q, qk_busy_q, ready;
  logic [31:0] rob_q [RS_SIZE];
  logic [31:0] qj_q [RS_SIZE];
  logic [31:0] qk_q [RS_SIZE];
  logic [31:0] vj_q [RS_SIZE];
  logic [31:0] vk_q [RS_SIZE];
  logic [31:0] imm_q [RS_SIZE];
  logic [4:0]  type_q [RS_SIZE];
  logic [IW-1:0] sel, free;
  logic do_issue, fwd_j, fwd_k;

  assign ready = busy_q & ~qj_busy_q & ~qk_busy_q;
  assign full = &busy_q;
  assign do_issue = issue_valid && !full;
  assign fwd_j = cdb_valid && issue_qj_busy && issue_qj == cdb_rob_id;
  assign fwd_k = cdb_valid && issue_qk_busy && issue_qk == cdb_rob_id;

  // descending scan so the lowest index wins; sel is always busy and free never is, so they cannot collide
  always_comb begin
    sel = '0;
    free = '0;
    for (int i = RS_SIZE - 1; i >= 0; i--) begin
      if (ready[i]) sel = IW'(i);
      if (!busy_q[i]) free = IW'(i);
    end
    busy_d = busy_q;
    if (|ready) busy_d[sel] = 1'b0;
    if (do_issue) busy_d[free] = 1'b1;
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      busy_q <= '0;
      alu_en <= 1'b0;
      alu_rob_id <= '0;
      alu_data_j <= '0;
      alu_data_k <= '0;
      alu_imm <= '0;
      alu_type <= '0;
    end else if (rdy_in) begin
      if (flush) begin
        busy_q <= '0;
        alu_en <= 1'b0;
      end else begin
        busy_q <= busy_d;
        alu_en <= |ready;
        if (|ready) begin
          alu_rob_id <= rob_q[sel];
          alu_data_j <= vj_q[sel];
          alu_data_k <= vk_q[sel];
          alu_imm <= imm_q[sel];
          alu_type <= type_q[sel];
        end
      end
    end
  end

  // entry payload is only meaningful while busy, so it needs no reset
  always_ff @(posedge clk_in) begin
    if (rdy_in && !flush) begin
      for (int i = 0; i < RS_SIZE; i++) begin
        if (busy_q[i] && qj_busy_q[i] && cdb_valid && qj_q[i] == cdb_rob_id) begin
          vj_q[i] <= cdb_value;
          qj_busy_q[i] <= 1'b0;
        end
        if (busy_q[i] && qk_busy_q[i] && cdb_valid && qk_q[i] == cdb_rob_id) begin
          vk_q[i] <= cdb_value;
          qk_busy_q[i] <= 1'b0;
        end
      end
      if (do_issue) begin
        rob_q[free] <= issue_rob_id;
        type_q[free] <= issue_type;
        imm_q[free] <= issue_imm;
        qj_q[free] <= issue_qj;
        qk_q[free] <= issue_qk;
        qj_busy_q[free] <= issue_qj_busy && !fwd_j;
        qk_busy_q[free] <= issue_qk_busy && !fwd_k;
        vj_q[free] <= fwd_j ? cdb_value : issue_vj;
        vk_q[free] <= fwd_k ? cdb_value : issue_vk;
      end
    end
  end
endmodule

// File: tb/tb_reservation_station.sv
// tb_reservation_station: directed scenario tasks with inline expected-value checks.
module tb_reservation_station;
  logic clk_in = 1'b0, rst_in = 1'b1, rdy_in = 1'b1, flush = 1'b0;
  logic issue_valid = 1'b0, issue_qj_busy = 1'b0, issue_qk_busy = 1'b0;
  logic [31:0] issue_rob_id = '0, issue_qj = '0, issue_qk = '0, issue_vj = '0, issue_vk = '0, issue_imm = '0;
  logic [4:0] issue_type = '0;
  logic cdb_valid = 1'b0;
  logic [31:0] cdb_rob_id = '0, cdb_value = '0;
  logic full, alu_en;
  logic [31:0] alu_rob_id, alu_data_j, alu_data_k, alu_imm;
  logic [4:0] alu_type;
  int asserts = 0, fails = 0;

  reservation_station #(.RS_SIZE(8)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .flush(flush),
    .issue_valid(issue_valid), .issue_rob_id(issue_rob_id), .issue_type(issue_type),
    .issue_qj_busy(issue_qj_busy), .issue_qk_busy(issue_qk_busy),
    .issue_qj(issue_qj), .issue_qk(issue_qk), .issue_vj(issue_vj), .issue_vk(issue_vk),
    .issue_imm(issue_imm), .full(full),
    .cdb_valid(cdb_valid), .cdb_rob_id(cdb_rob_id), .cdb_value(cdb_value),
    .alu_en(alu_en), .alu_rob_id(alu_rob_id), .alu_data_j(alu_data_j),
    .alu_data_k(alu_data_k), .alu_imm(alu_imm), .alu_type(alu_type)
  );

  always #5 clk_in = ~clk_in;

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic issue(input logic [31:0] rob, input logic [4:0] ty, input logic jb, input logic [31:0] qj,
                       input logic [31:0] vj, input logic kb, input logic [31:0] qk, input logic [31:0] vk);
    issue_valid = 1'b1; issue_rob_id = rob; issue_type = ty; issue_imm = rob + 32'h100;
    issue_qj_busy = jb; issue_qj = qj; issue_vj = vj;
    issue_qk_busy = kb; issue_qk = qk; issue_vk = vk;
  endtask

  task automatic idle();
    issue_valid = 1'b0; cdb_valid = 1'b0; flush = 1'b0;
  endtask

  task automatic test_reset();
    #2;
    asserts++; if (alu_en !== 1'b0) begin fails++; $display("FAIL reset_en got %0b want 0", alu_en); end
    asserts++; if (full !== 1'b0) begin fails++; $display("FAIL reset_full got %0b want 0", full); end
    asserts++; if ({alu_rob_id, alu_data_j, alu_data_k, alu_imm, alu_type} !== '0) begin fails++; $display("FAIL reset_payload got %h want 0", alu_rob_id); end
    tick();
    rst_in = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    issue(3, 5'd0, 0, 0, 5, 0, 0, 7);
    tick();
    idle();
    asserts++; if (alu_en !== 1'b0) begin fails++; $display("FAIL basic_early got %0b want 0", alu_en); end
    tick();
    asserts++; if (alu_en !== 1'b1) begin fails++; $display("FAIL basic_en got %0b want 1", alu_en); end
    asserts++; if (alu_rob_id !== 32'd3 || alu_data_j !== 32'd5 || alu_data_k !== 32'd7) begin fails++; $display("FAIL basic_payload got %0d/%0d/%0d want 3/5/7", alu_rob_id, alu_data_j, alu_data_k); end
    asserts++; if (alu_imm !== 32'h103 || alu_type !== 5'd0) begin fails++; $display("FAIL basic_imm got %h/%0d want 103/0", alu_imm, alu_type); end
    asserts++; if (full !== 1'b0) begin fails++; $display("FAIL basic_full got %0b want 0", full); end
    tick();
    asserts++; if (alu_en !== 1'b0) begin fails++; $display("FAIL basic_pulse got %0b want 0", alu_en); end
  endtask

  task automatic test_wakeup();
    issue(4, 5'd3, 1, 2, 0, 0, 0, 1);
    tick();
    idle();
    for (int i = 0; i < 2; i++) begin
      tick();
      asserts++; if (alu_en !== 1'b0) begin fails++; $display("FAIL wake_wait%0d got %0b want 0", i, alu_en); end
    end
    cdb_valid = 1'b1; cdb_rob_id = 2; cdb_value = 32'h10;
    tick();
    idle();
    asserts++; if (alu_en !== 1'b0) begin fails++; $display("FAIL wake_edge got %0b want 0", alu_en); end
    tick();
    asserts++; if (alu_en !== 1'b1 || alu_rob_id !== 32'd4 || alu_data_j !== 32'h10 || alu_data_k !== 32'd1 || alu_type !== 5'd3) begin fails++; $display("FAIL wake_disp got en=%0b rob=%0d j=%h k=%0d want 1/4/10/1", alu_en, alu_rob_id, alu_data_j, alu_data_k); end
    tick();
    asserts++; if (alu_en !== 1'b0) begin fails++; $display("FAIL wake_pulse got %0b want 0", alu_en); end
  endtask

  task automatic test_forward();
    issue(9, 5'd7, 0, 0, 3, 1, 6, 0);
    cdb_valid = 1'b1; cdb_rob_id = 6; cdb_value = 32'hAB;
    tick();
    idle();
    tick();
    asserts++; if (alu_en !== 1'b1 || alu_rob_id !== 32'd9 || alu_data_k !== 32'hAB || alu_data_j !== 32'd3) begin fails++; $display("FAIL fwd_disp got en=%0b rob=%0d k=%h j=%0d want 1/9/ab/3", alu_en, alu_rob_id, alu_data_k, alu_data_j); end
    tick();
  endtask

  task automatic test_fill();
    for (int i = 0; i < 8; i++) begin
      issue(10 + i, 5'd1, 1, 1, 0, 0, 0, i);
      tick();
    end
    asserts++; if (full !== 1'b1) begin fails++; $display("FAIL fill_full got %0b want 1", full); end
    issue(99, 5'd2, 0, 0, 1, 0, 0, 1);
    tick();
    idle();
    asserts++; if (alu_en !== 1'b0 || full !== 1'b1) begin fails++; $display("FAIL fill_drop got en=%0b full=%0b want 0/1", alu_en, full); end
    cdb_valid = 1'b1; cdb_rob_id = 1; cdb_value = 32'h55;
    tick();
    idle();
    asserts++; if (alu_en !== 1'b0) begin fails++; $display("FAIL fill_wake got %0b want 0", alu_en); end
    for (int i = 0; i < 8; i++) begin
      tick();
      asserts++; if (alu_en !== 1'b1 || alu_rob_id !== 32'(10 + i) || alu_data_j !== 32'h55 || alu_data_k !== 32'(i)) begin fails++; $display("FAIL fill_disp%0d got en=%0b rob=%0d j=%h want 1/%0d/55", i, alu_en, alu_rob_id, alu_data_j, 10 + i); end
      asserts++; if (full !== 1'b0) begin fails++; $display("FAIL fill_full%0d got %0b want 0", i, full); end
    end
    tick();
    asserts++; if (alu_en !== 1'b0) begin fails++; $display("FAIL fill_extra got %0b want 0", alu_en); end
  endtask

  task automatic test_flush();
    issue(20, 5'd1, 1, 7, 0, 0, 0, 0);
    tick();
    issue(21, 5'd1, 0, 0, 1, 0, 0, 1);
    tick();
    issue(22, 5'd1, 0, 0, 2, 0, 0, 2);
    flush = 1'b1;
    tick();
    idle();
    asserts++; if (full !== 1'b0 || alu_en !== 1'b0) begin fails++; $display("FAIL flush_state got full=%0b en=%0b want 0/0", full, alu_en); end
    asserts++; if (alu_rob_id !== 32'd17) begin fails++; $display("FAIL flush_hold got %0d want 17", alu_rob_id); end
    cdb_valid = 1'b1; cdb_rob_id = 7; cdb_value = 32'h1;
    tick();
    idle();
    for (int i = 0; i < 3; i++) begin
      asserts++; if (alu_en !== 1'b0) begin fails++; $display("FAIL flush_nodisp%0d got %0b want 0", i, alu_en); end
      tick();
    end
  endtask

  task automatic test_rdy_reset();
    issue(31, 5'd4, 1, 5, 0, 0, 0, 0);
    tick();
    issue(30, 5'd4, 0, 0, 8, 0, 0, 9);
    tick();
    rdy_in = 1'b0;
    issue(32, 5'd4, 0, 0, 0, 0, 0, 0);
    cdb_valid = 1'b1; cdb_rob_id = 5; cdb_value = 32'h77;
    for (int i = 0; i < 3; i++) begin
      tick();
      asserts++; if (alu_en !== 1'b0) begin fails++; $display("FAIL rdy_frozen%0d got %0b want 0", i, alu_en); end
    end
    idle();
    rdy_in = 1'b1;
    tick();
    asserts++; if (alu_en !== 1'b1 || alu_rob_id !== 32'd30 || alu_data_j !== 32'd8) begin fails++; $display("FAIL rdy_resume got en=%0b rob=%0d want 1/30", alu_en, alu_rob_id); end
    tick();
    asserts++; if (alu_en !== 1'b0) begin fails++; $display("FAIL rdy_nowake got %0b want 0", alu_en); end
    cdb_valid = 1'b1; cdb_rob_id = 5; cdb_value = 32'h88;
    tick();
    idle();
    tick();
    asserts++; if (alu_en !== 1'b1 || alu_rob_id !== 32'd31 || alu_data_j !== 32'h88) begin fails++; $display("FAIL rdy_wake got en=%0b rob=%0d j=%h want 1/31/88", alu_en, alu_rob_id, alu_data_j); end
    issue(40, 5'd6, 0, 0, 4, 0, 0, 4);
    tick();
    idle();
    tick();
    asserts++; if (alu_en !== 1'b1 || alu_rob_id !== 32'd40) begin fails++; $display("FAIL rst_pre got en=%0b rob=%0d want 1/40", alu_en, alu_rob_id); end
    #2 rst_in = 1'b1;
    #1;
    asserts++; if (alu_en !== 1'b0 || {alu_rob_id, alu_data_j, alu_data_k, alu_imm, alu_type} !== '0) begin fails++; $display("FAIL rst_async got en=%0b rob=%0d want 0/0", alu_en, alu_rob_id); end
    asserts++; if (full !== 1'b0) begin fails++; $display("FAIL rst_full got %0b want 0", full); end
    #1 rst_in = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wakeup();
    test_forward();
    test_fill();
    test_flush();
    test_rdy_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
    $finish;
  end
endmodule
